rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port (reg_write/write_addr/write_data) between two

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rf_arb_fifo.sv | 74 +++++++
 rtl/rf_write_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared widths, grant/state encodings and the write-port request record for the
// register-file write arbiter.
package rf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_WB   = 2'd1;
  localparam logic [1:0] GNT_MDU  = 2'd2;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_DRAIN = 2'd1;
  localparam logic [1:0] ARB_FORCE = 2'd2;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// DEPTH-entry {addr,data} buffer for MDU results; exposes per-entry valid and
// destination so the top can answer decode hazard queries.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [REG_AW-1:0]             i_addr,
  input  logic [XLEN-1:0]               i_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [REG_AW-1:0]             o_head_addr,
  output logic [XLEN-1:0]               o_head_data,
  output logic [DEPTH-1:0]              o_vld,
  output logic [DEPTH-1:0][REG_AW-1:0]  o_addrs
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]                 r_rd, r_wr;
  logic [PW:0]                   r_cnt;
  logic [DEPTH-1:0]              r_vld;
  logic [DEPTH-1:0][REG_AW-1:0]  r_addr;
  logic [DEPTH-1:0][XLEN-1:0]    r_data;
  logic                          w_push, w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
    end else begin
      // push and pop never target the same slot: that needs full or empty
      if (w_push) begin
        r_vld[r_wr] <= 1'b1;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= r_rd + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr] <= i_addr;
      r_data[r_wr] <= i_data;
    end
  end

  assign o_count     = r_cnt;
  assign o_head_addr = r_addr[r_rd];
  assign o_head_data = r_data[r_rd];
  assign o_vld       = r_vld;
  assign o_addrs     = r_addr;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (priority) and buffered MDU
// results, with a starvation override and pending-destination hazard lookups.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic               wb_ready,
  input  logic               mdu_valid,
  input  logic [REG_AW-1:0]  mdu_addr,
  input  logic [XLEN-1:0]    mdu_data,
  output logic               mdu_ready,
  input  logic [REG_AW-1:0]  chk_addr0,
  input  logic [REG_AW-1:0]  chk_addr1,
  input  logic [REG_AW-1:0]  chk_addr2,
  output logic [2:0]         pending_hit,
  output logic               reg_write,
  output logic [REG_AW-1:0]  write_addr,
  output logic [XLEN-1:0]    write_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                          w_full, w_empty;
  logic [CW-1:0]                 w_count;
  logic [REG_AW-1:0]             w_head_addr;
  logic [XLEN-1:0]               w_head_data;
  logic [DEPTH-1:0]              w_vld;
  logic [DEPTH-1:0][REG_AW-1:0]  w_addrs;
  logic [2:0][REG_AW-1:0]        w_chk;

  logic [1:0]     r_state;
  logic [SW-1:0]  r_starve;
  logic [1:0]     w_gnt;
  logic           w_force, w_push, w_pop, w_force_nxt, w_nonempty_nxt;

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_addr      (mdu_addr),
    .i_data      (mdu_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_vld       (w_vld),
    .o_addrs     (w_addrs)
  );

  assign w_force = (r_state == ARB_FORCE);

  always_comb begin
    w_gnt = GNT_NONE;
    if (!rstn)                   w_gnt = GNT_NONE;
    else if (w_force && !w_empty) w_gnt = GNT_MDU;
    else if (wb_valid)            w_gnt = GNT_WB;
    else if (!w_empty)            w_gnt = GNT_MDU;
  end

  always_comb begin
    reg_write  = 1'b0;
    write_addr = '0;
    write_data = '0;
    case (w_gnt)
      GNT_WB: begin
        // r0 writes complete the handshake but never touch the file
        reg_write  = (wb_addr != '0);
        write_addr = wb_addr;
        write_data = wb_data;
      end
      GNT_MDU: begin
        reg_write  = 1'b1;
        write_addr = w_head_addr;
        write_data = w_head_data;
      end
      default: ;
    endcase
  end

  assign wb_ready  = rstn && !(w_force && !w_empty);
  assign mdu_ready = rstn && !w_full;
  assign w_pop     = (w_gnt == GNT_MDU);
  assign w_push    = mdu_valid && mdu_ready && (mdu_addr != '0);

  assign w_force_nxt    = (r_starve == SW'(STARVE_LIMIT - 1)) && !w_pop && !w_empty;
  assign w_nonempty_nxt = w_push || !(w_empty || (w_pop && w_count == CW'(1)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_starve <= '0;
      r_state  <= ARB_IDLE;
    end else begin
      if (w_pop || w_empty)                  r_starve <= '0;
      else if (r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + SW'(1);
      if (w_force_nxt)         r_state <= ARB_FORCE;
      else if (w_nonempty_nxt) r_state <= ARB_DRAIN;
      else                     r_state <= ARB_IDLE;
    end
  end

  // an entry being popped this cycle still reports a hit until the edge lands it
  assign w_chk = {chk_addr2, chk_addr1, chk_addr0};

  for (genvar gi = 0; gi < 3; gi++) begin : g_hit
    logic [DEPTH-1:0] w_m;
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_ent
      assign w_m[gj] = w_vld[gj] && (w_addrs[gj] == w_chk[gi]);
    end
    assign pending_hit[gi] = rstn && (w_chk[gi] != '0) && (|w_m);
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_rf_write_arbiter;

  logic        clk, rstn;
  logic        wb_valid, wb_ready, mdu_valid, mdu_ready, reg_write;
  logic [4:0]  wb_addr, mdu_addr, chk_addr0, chk_addr1, chk_addr2, write_addr;
  logic [31:0] wb_data, mdu_data, write_data;
  logic [2:0]  pending_hit;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t mq[$];
  int   m_wait;
  bit   m_force;

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .pending_hit(pending_hit),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    chk_addr0 = 0; chk_addr1 = 0; chk_addr2 = 0;
  endtask

  task automatic test_reset();
    rstn = 0; wb_valid = 1; wb_addr = 5; wb_data = 32'h55;
    mdu_valid = 1; mdu_addr = 3; mdu_data = 32'h33; chk_addr0 = 3;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b want 0", reg_write); end
      checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_wb_ready: got %b want 0", wb_ready); end
      checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL reset_mdu_ready: got %b want 0", mdu_ready); end
      checks++; if (pending_hit !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b want 000", pending_hit); end
      tick();
    end
    rstn = 1; drive_idle(); chk_addr0 = 3;
    settle();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 0", reg_write); end
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_mdu_ready: got %b want 1", mdu_ready); end
    checks++; if (pending_hit !== 3'b000) begin errors++; $display("FAIL post_reset_pending: got %b want 000", pending_hit); end
    tick();
  endtask

  task automatic test_wb_only();
    drive_idle(); wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    settle();
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL wb_reg_write: got %b want 1", reg_write); end
    checks++; if (write_addr !== 5'd5) begin errors++; $display("FAIL wb_addr: got %0d want 5", write_addr); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_data: got %h want deadbeef", write_data); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_ready: got %b want 1", wb_ready); end
    tick();
    wb_addr = 0;
    settle();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL wb_r0_reg_write: got %b want 0", reg_write); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_r0_ready: got %b want 1", wb_ready); end
    tick();
    drive_idle();
  endtask

  task automatic test_mdu_idle();
    drive_idle(); mdu_valid = 1; mdu_addr = 7; mdu_data = 32'h12; chk_addr0 = 7;
    settle();
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL mdu_push_ready: got %b want 1", mdu_ready); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mdu_no_bypass: got %b want 0", reg_write); end
    checks++; if (pending_hit !== 3'b000) begin errors++; $display("FAIL mdu_incoming_hit: got %b want 000", pending_hit); end
    tick();
    mdu_valid = 0;
    settle();
    checks++; if (reg_write !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'h12) begin
      errors++; $display("FAIL mdu_drain: got we=%b a=%0d d=%h want we=1 a=7 d=12", reg_write, write_addr, write_data); end
    checks++; if (pending_hit !== 3'b001) begin errors++; $display("FAIL mdu_buffered_hit: got %b want 001", pending_hit); end
    tick();
    settle();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mdu_after_empty: got %b want 0", reg_write); end
    checks++; if (pending_hit !== 3'b000) begin errors++; $display("FAIL mdu_after_hit: got %b want 000", pending_hit); end
    tick();
    drive_idle();
  endtask

  task automatic test_full();
    drive_idle();
    wb_valid = 1; wb_addr = 1; wb_data = 32'h100;
    mdu_valid = 1; mdu_addr = 10; mdu_data = 32'hA;
    chk_addr0 = 10; chk_addr1 = 11; chk_addr2 = 12;
    settle();
    checks++; if (mdu_ready !== 1'b1 || write_addr !== 5'd1) begin
      errors++; $display("FAIL full_push1: got rdy=%b a=%0d want rdy=1 a=1", mdu_ready, write_addr); end
    tick();
    mdu_addr = 11; mdu_data = 32'hB; wb_data = 32'h101;
    settle();
    checks++; if (mdu_ready !== 1'b1 || write_data !== 32'h101) begin
      errors++; $display("FAIL full_push2: got rdy=%b d=%h want rdy=1 d=101", mdu_ready, write_data); end
    tick();
    mdu_addr = 12; mdu_data = 32'hC; wb_data = 32'h102;
    settle();
    checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_third_offer: got %b want 0", mdu_ready); end
    checks++; if (pending_hit !== 3'b011) begin errors++; $display("FAIL full_pending: got %b want 011", pending_hit); end
    tick();
    wb_valid = 0; mdu_addr = 0; mdu_data = 32'hEE;
    settle();
    checks++; if (reg_write !== 1'b1 || write_addr !== 5'd10 || write_data !== 32'hA) begin
      errors++; $display("FAIL full_drain1: got we=%b a=%0d d=%h want we=1 a=10 d=a", reg_write, write_addr, write_data); end
    tick();
    settle();
    checks++; if (write_addr !== 5'd11 || mdu_ready !== 1'b1) begin
      errors++; $display("FAIL full_drain2: got a=%0d rdy=%b want a=11 rdy=1", write_addr, mdu_ready); end
    tick();
    mdu_valid = 0;
    settle();
    checks++; if (reg_write !== 1'b0 || pending_hit !== 3'b000) begin
      errors++; $display("FAIL full_r0_push_dropped: got we=%b hit=%b want we=0 hit=000", reg_write, pending_hit); end
    tick();
    drive_idle();
  endtask

  task automatic test_starvation();
    drive_idle();
    wb_valid = 1; wb_addr = 2; wb_data = 32'h200;
    mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h99;
    tick();
    mdu_valid = 0; mdu_addr = 0;
    for (int c = 1; c <= 4; c++) begin
      wb_data = 32'h200 + c;
      settle();
      checks++; if (wb_ready !== 1'b1 || write_data !== wb_data) begin
        errors++; $display("FAIL starve_wait%0d: got rdy=%b d=%h want rdy=1 d=%h", c, wb_ready, write_data, wb_data); end
      tick();
    end
    wb_data = 32'h205;
    settle();
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL starve_force_ready: got %b want 0", wb_ready); end
    checks++; if (reg_write !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'h99) begin
      errors++; $display("FAIL starve_force_write: got we=%b a=%0d d=%h want we=1 a=9 d=99", reg_write, write_addr, write_data); end
    tick();
    settle();
    checks++; if (wb_ready !== 1'b1 || write_addr !== 5'd2 || write_data !== 32'h205) begin
      errors++; $display("FAIL starve_wb_after: got rdy=%b a=%0d d=%h want rdy=1 a=2 d=205", wb_ready, write_addr, write_data); end
    tick();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    wb_valid = 1; wb_addr = 3; mdu_valid = 1; mdu_addr = 20; mdu_data = 32'h20;
    tick();
    mdu_addr = 21; mdu_data = 32'h21;
    tick();
    rstn = 0; mdu_valid = 0; chk_addr0 = 20; chk_addr1 = 21;
    settle();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL midreset_no_write: got %b want 0", reg_write); end
    tick();
    rstn = 1; wb_valid = 0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (reg_write !== 1'b0 || pending_hit !== 3'b000) begin
        errors++; $display("FAIL midreset_discard%0d: got we=%b hit=%b want we=0 hit=000", c, reg_write, pending_hit); end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_random();
    bit          hold;
    int          src;
    logic        e_wbr, e_mdr, e_we;
    logic [4:0]  e_wa, chk;
    logic [31:0] e_wd;
    logic [2:0]  e_hit;
    bit          ne;
    drive_idle();
    rstn = 0; tick();
    mq.delete(); m_wait = 0; m_force = 0; hold = 0;
    rstn = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rstn = ($urandom_range(0, 79) != 0);
      if (!hold) begin
        wb_valid = ($urandom_range(0, 2) != 0);
        wb_addr  = 5'($urandom_range(0, 7));
        wb_data  = $urandom;
      end
      mdu_valid = ($urandom_range(0, 1) != 0);
      mdu_addr  = 5'($urandom_range(0, 7));
      mdu_data  = $urandom;
      chk_addr0 = 5'($urandom_range(0, 7));
      chk_addr1 = 5'($urandom_range(0, 7));
      chk_addr2 = 5'($urandom_range(0, 7));
      settle();
      ne    = (mq.size() > 0);
      e_wbr = rstn && !(m_force && ne);
      e_mdr = rstn && (mq.size() < 2);
      if (!rstn) src = 0;
      else if (m_force && ne) src = 2;
      else if (wb_valid) src = 1;
      else if (ne) src = 2;
      else src = 0;
      e_we = 0; e_wa = 0; e_wd = 0;
      if (src == 1) begin e_we = (wb_addr != 0); e_wa = wb_addr; e_wd = wb_data; end
      if (src == 2) begin e_we = 1; e_wa = mq[0].a; e_wd = mq[0].d; end
      e_hit = 0;
      for (int i = 0; i < 3; i++) begin
        chk = (i == 0) ? chk_addr0 : (i == 1) ? chk_addr1 : chk_addr2;
        foreach (mq[k]) if (rstn && chk != 0 && mq[k].a == chk) e_hit[i] = 1;
      end
      checks++; if (wb_ready !== e_wbr) begin errors++; $display("FAIL rnd_wb_ready cyc%0d: got %b want %b", cyc, wb_ready, e_wbr); end
      checks++; if (mdu_ready !== e_mdr) begin errors++; $display("FAIL rnd_mdu_ready cyc%0d: got %b want %b", cyc, mdu_ready, e_mdr); end
      checks++; if (reg_write !== e_we) begin errors++; $display("FAIL rnd_reg_write cyc%0d: got %b want %b", cyc, reg_write, e_we); end
      if (e_we) begin
        checks++; if (write_addr !== e_wa || write_data !== e_wd) begin
          errors++; $display("FAIL rnd_write cyc%0d: got a=%0d d=%h want a=%0d d=%h", cyc, write_addr, write_data, e_wa, e_wd); end
      end
      checks++; if (pending_hit !== e_hit) begin errors++; $display("FAIL rnd_pending cyc%0d: got %b want %b", cyc, pending_hit, e_hit); end
      // reference model advances at the edge
      if (!rstn) begin
        mq.delete(); m_wait = 0; m_force = 0;
      end else begin
        if (src == 2) void'(mq.pop_front());
        if (mdu_valid && e_mdr && mdu_addr != 0) mq.push_back('{a: mdu_addr, d: mdu_data});
        m_force = (m_wait == 3) && (src != 2) && ne;
        if (src == 2 || !ne) m_wait = 0;
        else if (m_wait < 4) m_wait++;
      end
      hold = wb_valid && !e_wbr;
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rstn = 0;
    test_reset();
    test_wb_only();
    test_mdu_idle();
    test_full();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
